swap_cmd_sequencer: RTL and testbench
=====================================

Name: swap_cmd_sequencer

Overview:
- Command front-end that sits directly upstream of the three-register bus swap unit.
- Accepts load/swap commands over a valid/ready handshake and buffers them in a small FIFO.
- Drives the swap unit's Data, RinExt1..3 and w inputs, then waits on its Done output before issuing the next command.
- Guarantees that RinExt is never asserted while the swap unit owns the bus.

Parameters:
- n, 8, data/bus width; must match the swap unit.
- DEPTH, 4, command FIFO entries; must be a power of 2, at least 2.
- TIMEOUT, 15, maximum cycles spent in SWAP_WAIT; used only with the optional feature.

Ports:
- Clock  in  1  system clock, rising edge.
- Resetn  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO can accept; equals not full.
- cmd_op  in  2  00 NOP, 01 LOAD, 10 SWAP, 11 illegal.
- cmd_sel  in  2  LOAD target register 1..3; 00 is illegal for LOAD.
- cmd_data  in  n  LOAD value.
- Done  in  1  swap unit Done.
- Data  out  n  to swap unit Data.
- RinExt1, RinExt2, RinExt3  out  1 each  external load enables.
- w  out  1  swap start.
- busy  out  1  high unless state is IDLE and FIFO is empty.
- fifo_count  out  log2(DEPTH)+1  number of FIFO entries.
- err_illegal  out  1  sticky illegal-command flag.
- err_timeout  out  1  sticky Done-timeout flag.

Behaviour:
- Reset values: all outputs 0, except cmd_ready=1. State is IDLE, FIFO empty.
- Handshake and push: a command is pushed when cmd_valid && cmd_ready at a clock edge. Payload is sampled only on the handshake. Push into a full FIFO cannot occur because cmd_ready=0.
- Simultaneous push and pop on a full FIFO: permitted, and fifo_count is unchanged. cmd_ready stays combinational on full only; it does not look ahead to the pop.
- Outputs: Data, RinExt1..3 and w are registered, all driven from the state register.
- State IDLE:
  - All enables 0.
  - If the FIFO is non-empty, pop the head at this edge.
  - LOAD with cmd_sel 1..3: capture cmd_data and cmd_sel, go to LOAD.
  - SWAP: go to SWAP_REQ.
  - NOP: stay IDLE.
  - Illegal (op 11, or LOAD with sel 00): set err_illegal, stay IDLE.
- State LOAD (1 cycle): Data=captured value, RinExt[sel]=1, other enables 0, then IDLE. A LOAD therefore costs 2 cycles from head-of-FIFO.
- State SWAP_REQ (1 cycle): w=1, Data=0, no RinExt, then SWAP_WAIT.
- State SWAP_WAIT:
  - w=0, no RinExt.
  - Leave for IDLE on the first cycle Done=1. The swap unit returns to its idle state on that same edge.
  - Nominal dwell is 3 cycles; SWAP_REQ to IDLE is 4 cycles.
- Done outside SWAP_WAIT is ignored.
- Sticky flags are cleared only by Resetn.
- Reset mid-operation: state goes to IDLE and the FIFO is flushed asynchronously. Outputs are 0 immediately, with no glitch enable held.
- FIFO pointers wrap modulo DEPTH. fifo_count ranges 0..DEPTH.

Optional Feature:
- Macro SWAPSEQ_TIMEOUT_EN.
- When defined:
  - A down-counter loads TIMEOUT on entry to SWAP_WAIT.
  - If it reaches 0 without Done, set err_timeout and return to IDLE.
  - Done and expiry in the same cycle count as success, with no error.
- When undefined: SWAP_WAIT waits indefinitely, err_timeout is tied to 0, and the counter logic is absent.

Decomposition:
- Shared package swap_pkg:
  - op encodings: OP_NOP, OP_LOAD, OP_SWAP, OP_ILL.
  - state encodings: IDLE, LOAD, SWAP_REQ, SWAP_WAIT as a 2-bit constant set.
  - command struct/width constant: op + sel + n.
- Natural sub-module: swap_cmd_fifo (parameter DEPTH, width 4+n).
  - Synchronous push/pop, async clear on Resetn.
  - Provides full, empty, count and head data; fall-through read of head.

Test Plan:
- After reset: push LOAD sel=2 data=8'hA5 -> RinExt2=1 and Data=A5 for exactly one cycle, 2 cycles after push; other enables 0.
- Push LOAD1=11, LOAD2=22, LOAD3=33, SWAP; model the swap unit -> w pulses one cycle, Done after 3 cycles, sequencer back to IDLE 4 cycles after w; afterwards R1=22, R2=11, R3=33.
- Hold downstream Done=0 (no swap unit) and push DEPTH+2 commands -> cmd_ready falls when fifo_count=DEPTH; no command is lost or duplicated after Done is finally released.
- Push op=11, then LOAD sel=0 -> err_illegal=1 after the first; no RinExt/w activity; the following legal LOAD still executes.
- Assert Resetn=0 during SWAP_WAIT with 3 queued commands -> all outputs 0, fifo_count=0, cmd_ready=1 asynchronously.
- With SWAPSEQ_TIMEOUT_EN and TIMEOUT=15, never assert Done -> err_timeout=1 after 15 cycles in SWAP_WAIT, state returns to IDLE; Done on the last cycle -> no error.

Source files
------------

// File: rtl/swap_pkg.sv
// Shared encodings for the swap-unit command sequencer and its command FIFO.
package swap_pkg;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_LOAD = 2'b01,
    OP_SWAP = 2'b10,
    OP_ILL  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    SWAP_REQ  = 2'd2,
    SWAP_WAIT = 2'd3
  } state_e;

  // A queued command is {op, sel, data}
  localparam int unsigned CMD_HDR_W = 4;

  function automatic int unsigned cmd_width(input int unsigned n);
    return CMD_HDR_W + n;
  endfunction

  function automatic logic cmd_is_legal(input logic [1:0] op, input logic [1:0] sel);
    logic ok;
    case (op)
      OP_NOP, OP_SWAP: ok = 1'b1;
      OP_LOAD:         ok = (sel != 2'b00);
      default:         ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/swap_cmd_fifo.sv
// Command FIFO with fall-through head, power-of-two depth and async clear on Resetn.
module swap_cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 12
) (
  input  logic                   Clock,
  input  logic                   Resetn,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           wdata,
  output logic [W-1:0]           rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          do_push_s;
  logic          do_pop_s;

  assign full      = (count_r == CW'(DEPTH));
  assign empty     = (count_r == CW'(0));
  assign count     = count_r;
  assign rdata     = mem_r[rd_ptr_r];
  assign do_pop_s  = pop && !empty;
  // A push into a full FIFO is only safe when the head leaves on the same edge
  assign do_push_s = push && (!full || do_pop_s);

  // Storage write; contents need no reset since count gates every read
  always_ff @(posedge Clock) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointer and occupancy tracking
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/swap_cmd_sequencer.sv
// Command front-end for the three-register swap unit: FIFO-buffered LOAD/SWAP
// sequencing. Define SWAPSEQ_TIMEOUT_EN to add a Done watchdog in SWAP_WAIT.
module swap_cmd_sequencer
  import swap_pkg::*;
#(
  parameter int unsigned n       = 8,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                   Clock,
  input  logic                   Resetn,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [1:0]             cmd_sel,
  input  logic [n-1:0]           cmd_data,
  input  logic                   Done,
  output logic [n-1:0]           Data,
  output logic                   RinExt1,
  output logic                   RinExt2,
  output logic                   RinExt3,
  output logic                   w,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   err_illegal,
  output logic                   err_timeout
);
  localparam int unsigned CMD_W = cmd_width(n);

  state_e         state_r;
  logic [CMD_W-1:0] head_s;
  logic [1:0]     head_op_s;
  logic [1:0]     head_sel_s;
  logic [n-1:0]   head_data_s;
  logic           full_s;
  logic           empty_s;
  logic           push_s;
  logic           pop_s;

  assign cmd_ready   = !full_s;
  assign push_s      = cmd_valid && !full_s;
  assign pop_s       = (state_r == IDLE) && !empty_s;
  assign busy        = (state_r != IDLE) || !empty_s;
  assign head_op_s   = head_s[CMD_W-1 -: 2];
  assign head_sel_s  = head_s[n+1 -: 2];
  assign head_data_s = head_s[n-1:0];

  swap_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (CMD_W)
  ) u_fifo (
    .Clock  (Clock),
    .Resetn (Resetn),
    .push   (push_s),
    .pop    (pop_s),
    .wdata  ({cmd_op, cmd_sel, cmd_data}),
    .rdata  (head_s),
    .full   (full_s),
    .empty  (empty_s),
    .count  (fifo_count)
  );

`ifdef SWAPSEQ_TIMEOUT_EN
  localparam int unsigned WDOG_W = $clog2(TIMEOUT + 1);
  logic [WDOG_W-1:0] wdog_r;
`else
  assign err_timeout = 1'b0;
`endif

  // Sequencer FSM; bus enables are registered alongside the state they belong to
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_r     <= IDLE;
      Data        <= '0;
      RinExt1     <= 1'b0;
      RinExt2     <= 1'b0;
      RinExt3     <= 1'b0;
      w           <= 1'b0;
      err_illegal <= 1'b0;
`ifdef SWAPSEQ_TIMEOUT_EN
      err_timeout <= 1'b0;
      wdog_r      <= '0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          Data    <= '0;
          RinExt1 <= 1'b0;
          RinExt2 <= 1'b0;
          RinExt3 <= 1'b0;
          w       <= 1'b0;
          if (!empty_s) begin
            if (!cmd_is_legal(head_op_s, head_sel_s)) begin
              err_illegal <= 1'b1;
            end else begin
              case (head_op_s)
                OP_LOAD: begin
                  state_r <= LOAD;
                  Data    <= head_data_s;
                  RinExt1 <= (head_sel_s == 2'd1);
                  RinExt2 <= (head_sel_s == 2'd2);
                  RinExt3 <= (head_sel_s == 2'd3);
                end
                OP_SWAP: begin
                  state_r <= SWAP_REQ;
                  w       <= 1'b1;
                end
                default: state_r <= IDLE;
              endcase
            end
          end
        end
        LOAD: begin
          state_r <= IDLE;
          Data    <= '0;
          RinExt1 <= 1'b0;
          RinExt2 <= 1'b0;
          RinExt3 <= 1'b0;
        end
        SWAP_REQ: begin
          state_r <= SWAP_WAIT;
          w       <= 1'b0;
`ifdef SWAPSEQ_TIMEOUT_EN
          wdog_r  <= WDOG_W'(TIMEOUT);
`endif
        end
        SWAP_WAIT: begin
          // Done on the final watchdog cycle still counts as success
          if (Done) begin
            state_r <= IDLE;
`ifdef SWAPSEQ_TIMEOUT_EN
          end else if (wdog_r <= WDOG_W'(1)) begin
            err_timeout <= 1'b1;
            state_r     <= IDLE;
          end else begin
            wdog_r <= wdog_r - WDOG_W'(1);
`else
          end else begin
            state_r <= SWAP_WAIT;
`endif
          end
        end
        default: begin
          state_r <= IDLE;
          Data    <= '0;
          RinExt1 <= 1'b0;
          RinExt2 <= 1'b0;
          RinExt3 <= 1'b0;
          w       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_swap_cmd_sequencer.sv
// Self-checking bench for swap_cmd_sequencer with a behavioural swap unit and
// an event-level reference model of the command stream.
module tb_swap_cmd_sequencer;
  import swap_pkg::*;

  localparam int N       = 8;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 15;

  logic                   Clock = 1'b0;
  logic                   Resetn = 1'b0;
  logic                   cmd_valid = 1'b0;
  logic                   cmd_ready;
  logic [1:0]             cmd_op = 2'b00;
  logic [1:0]             cmd_sel = 2'b00;
  logic [N-1:0]           cmd_data = '0;
  logic                   Done;
  logic [N-1:0]           Data;
  logic                   RinExt1, RinExt2, RinExt3, w, busy;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   err_illegal, err_timeout;

  int tests = 0;
  int fails = 0;

  always #5 Clock = ~Clock;

  swap_cmd_sequencer #(.n(N), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .Clock(Clock), .Resetn(Resetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_sel(cmd_sel), .cmd_data(cmd_data), .Done(Done),
    .Data(Data), .RinExt1(RinExt1), .RinExt2(RinExt2), .RinExt3(RinExt3), .w(w),
    .busy(busy), .fifo_count(fifo_count), .err_illegal(err_illegal),
    .err_timeout(err_timeout)
  );

  // Behavioural swap unit: three cycles after w it raises Done and exchanges R1/R2
  logic [1:0]   phase = 2'd0;
  logic [N-1:0] r1 = '0, r2 = '0, r3 = '0;
  logic         hold_done = 1'b0, rand_stall = 1'b0, stall_bit = 1'b0;
  assign Done = (phase == 2'd3) && !hold_done && !stall_bit;

  always @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      phase <= 2'd0; r1 <= '0; r2 <= '0; r3 <= '0; stall_bit <= 1'b0;
    end else begin
      stall_bit <= rand_stall ? 1'($urandom_range(0, 1)) : 1'b0;
      if (RinExt1) r1 <= Data;
      if (RinExt2) r2 <= Data;
      if (RinExt3) r3 <= Data;
      case (phase)
        2'd0:    if (w) phase <= 2'd1;
        2'd1:    phase <= 2'd2;
        2'd2:    phase <= 2'd3;
        default: if (Done) begin r1 <= r2; r2 <= r1; phase <= 2'd0; end
      endcase
    end
  end

  // Observed bus events {kind, sel, data} and protocol violations
  logic [N+3:0] obs[$];
  int           viol = 0;
  logic         w_prev = 1'b0;
  always @(negedge Clock) begin
    if (Resetn) begin
      if (RinExt1 || RinExt2 || RinExt3)
        obs.push_back({2'b01, RinExt3 ? 2'd3 : (RinExt2 ? 2'd2 : 2'd1), Data});
      if (w) obs.push_back({2'b10, 2'b00, {N{1'b0}}});
      viol <= viol + int'($countones({RinExt1, RinExt2, RinExt3, w}) > 1)
                   + int'((RinExt1 || RinExt2 || RinExt3) && phase != 2'd0)
                   + int'(w && w_prev)
                   + int'(32'(fifo_count) > DEPTH)
                   + int'(cmd_ready != (32'(fifo_count) != DEPTH));
    end
    w_prev <= w;
  end

  // Reference model: expected bus events and register contents from accepted commands
  logic [N+3:0] exp_q[$];
  logic         exp_ill;
  logic [N-1:0] er1, er2, er3;
  int           obs_base, viol_base;

  typedef struct {
    logic [1:0]   op;
    logic [1:0]   sel;
    logic [N-1:0] data;
    logic [3:0]   exp_en;   // {RinExt3, RinExt2, RinExt1, w}
    logic [N-1:0] exp_data;
    logic         exp_ill;
  } vec_t;
  vec_t vecs[7];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic model_accept(input logic [1:0] op, input logic [1:0] sel, input logic [N-1:0] d);
    case (op)
      OP_LOAD: begin
        if (sel == 2'd0) exp_ill = 1'b1;
        else begin
          exp_q.push_back({2'b01, sel, d});
          if (sel == 2'd1) er1 = d; else if (sel == 2'd2) er2 = d; else er3 = d;
        end
      end
      OP_SWAP: begin
        exp_q.push_back({2'b10, 2'b00, {N{1'b0}}});
        {er1, er2} = {er2, er1};
      end
      OP_NOP:  ;
      default: exp_ill = 1'b1;
    endcase
  endtask

  task automatic do_reset();
    Resetn = 1'b0; cmd_valid = 1'b0; hold_done = 1'b0; rand_stall = 1'b0;
    exp_q.delete(); exp_ill = 1'b0; er1 = '0; er2 = '0; er3 = '0;
    repeat (2) @(negedge Clock);
    Resetn = 1'b1;
    obs_base = obs.size();
    viol_base = viol;
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge
  task automatic push(input logic [1:0] op, input logic [1:0] sel, input logic [N-1:0] d);
    int   waited = 0;
    logic acc = 1'b0;
    cmd_valid = 1'b1; cmd_op = op; cmd_sel = sel; cmd_data = d;
    while (!acc && waited < 300) begin
      acc = cmd_ready;
      @(negedge Clock);
      waited++;
    end
    cmd_valid = 1'b0;
    check("push_accept", 32'(acc), 32'd1);
    if (acc) model_accept(op, sel, d);
  endtask

  task automatic wait_w();
    int k = 0;
    while (!w && k < 60) begin @(negedge Clock); k++; end
    check("w_seen", 32'(w), 32'd1);
  endtask

  task automatic wait_idle(input int limit);
    int k = 0;
    while (busy && k < limit) begin @(negedge Clock); k++; end
    check("drain_idle", 32'(busy), 32'd0);
  endtask

  task automatic compare_all(input string nm);
    int n_obs = obs.size() - obs_base;
    check({nm, "_events"}, 32'(n_obs), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < n_obs; i++)
      check($sformatf("%s_ev%0d", nm, i), 32'(obs[obs_base + i]), 32'(exp_q[i]));
    check({nm, "_r1"}, 32'(r1), 32'(er1));
    check({nm, "_r2"}, 32'(r2), 32'(er2));
    check({nm, "_r3"}, 32'(r3), 32'(er3));
    check({nm, "_illegal"}, 32'(err_illegal), 32'(exp_ill));
    check({nm, "_invariants"}, 32'(viol - viol_base), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{OP_LOAD, 2'd2, 8'hA5, 4'b0100, 8'hA5, 1'b0};
    vecs[1] = '{OP_LOAD, 2'd1, 8'h3C, 4'b0010, 8'h3C, 1'b0};
    vecs[2] = '{OP_LOAD, 2'd3, 8'hFF, 4'b1000, 8'hFF, 1'b0};
    vecs[3] = '{OP_SWAP, 2'd0, 8'h77, 4'b0001, 8'h00, 1'b0};
    vecs[4] = '{OP_NOP,  2'd1, 8'h12, 4'b0000, 8'h00, 1'b0};
    vecs[5] = '{OP_ILL,  2'd2, 8'h55, 4'b0000, 8'h00, 1'b1};
    vecs[6] = '{OP_LOAD, 2'd0, 8'h66, 4'b0000, 8'h00, 1'b1};

    // Reset state while Resetn is held low
    #12;
    check("reset_outputs", 32'({Data, RinExt1, RinExt2, RinExt3, w, busy, err_illegal, err_timeout}), 32'd0);
    check("reset_count", 32'(fifo_count), 32'd0);
    check("reset_ready", 32'(cmd_ready), 32'd1);

    // Single-command vectors: outputs appear two cycles after the push, for one cycle
    for (int i = 0; i < 7; i++) begin
      do_reset();
      push(vecs[i].op, vecs[i].sel, vecs[i].data);
      check($sformatf("vec%0d_count", i), 32'(fifo_count), 32'd1);
      @(negedge Clock);
      check($sformatf("vec%0d_en", i), 32'({RinExt3, RinExt2, RinExt1, w}), 32'(vecs[i].exp_en));
      check($sformatf("vec%0d_data", i), 32'(Data), 32'(vecs[i].exp_data));
      check($sformatf("vec%0d_illegal", i), 32'(err_illegal), 32'(vecs[i].exp_ill));
      @(negedge Clock);
      check($sformatf("vec%0d_en_off", i), 32'({RinExt3, RinExt2, RinExt1, w}), 32'd0);
    end

    // Load three registers then swap: w one cycle, back to IDLE four cycles after w
    do_reset();
    push(OP_LOAD, 2'd1, 8'h11);
    push(OP_LOAD, 2'd2, 8'h22);
    push(OP_LOAD, 2'd3, 8'h33);
    push(OP_SWAP, 2'd0, 8'h00);
    wait_w();
    @(negedge Clock);
    check("swap_w_pulse", 32'(w), 32'd0);
    repeat (2) @(negedge Clock);
    check("swap_busy_at3", 32'(busy), 32'd1);
    @(negedge Clock);
    check("swap_idle_at4", 32'(busy), 32'd0);
    check("swap_r1_value", 32'(r1), 32'h22);
    check("swap_r2_value", 32'(r2), 32'h11);
    compare_all("swap_seq");

    // Stalled Done: FIFO fills, ready drops at DEPTH, nothing lost or duplicated
    do_reset();
    hold_done = 1'b1;
    push(OP_SWAP, 2'd0, 8'h00);
    for (int i = 0; i < DEPTH; i++) push(OP_LOAD, 2'((i % 3) + 1), 8'(8'h40 + i));
    check("full_ready", 32'(cmd_ready), 32'd0);
    check("full_count", 32'(fifo_count), 32'(DEPTH));
    cmd_valid = 1'b1; cmd_op = OP_LOAD; cmd_sel = 2'd3; cmd_data = 8'hEE;
    repeat (4) @(negedge Clock);
    check("full_hold_count", 32'(fifo_count), 32'(DEPTH));
    hold_done = 1'b0;
    push(OP_LOAD, 2'd3, 8'hEE);
    wait_idle(200);
`ifndef SWAPSEQ_TIMEOUT_EN
    check("stall_no_timeout", 32'(err_timeout), 32'd0);
`endif
    compare_all("stall");

    // Illegal commands flag the error and produce no bus activity
    do_reset();
    push(OP_ILL, 2'd1, 8'hAA);
    @(negedge Clock);
    check("illegal_flag", 32'(err_illegal), 32'd1);
    push(OP_LOAD, 2'd0, 8'hBB);
    push(OP_LOAD, 2'd1, 8'h5A);
    wait_idle(50);
    compare_all("illegal");

    // Asynchronous reset while a LOAD drives the bus
    do_reset();
    push(OP_LOAD, 2'd3, 8'hC3);
    @(negedge Clock);
    check("midload_en", 32'(RinExt3), 32'd1);
    #2 Resetn = 1'b0;
    #1;
    check("midload_rst_en", 32'({RinExt3, RinExt2, RinExt1, w}), 32'd0);
    check("midload_rst_data", 32'(Data), 32'd0);

    // Asynchronous reset during SWAP_WAIT with three commands queued
    do_reset();
    hold_done = 1'b1;
    push(OP_SWAP, 2'd0, 8'h00);
    wait_w();
    @(negedge Clock);
    push(OP_LOAD, 2'd1, 8'h01);
    push(OP_LOAD, 2'd2, 8'h02);
    push(OP_SWAP, 2'd0, 8'h00);
    check("midswap_count", 32'(fifo_count), 32'd3);
    check("midswap_busy", 32'(busy), 32'd1);
    #2 Resetn = 1'b0;
    #1;
    check("midswap_rst_out", 32'({Data, RinExt1, RinExt2, RinExt3, w, busy}), 32'd0);
    check("midswap_rst_count", 32'(fifo_count), 32'd0);
    check("midswap_rst_ready", 32'(cmd_ready), 32'd1);

`ifdef SWAPSEQ_TIMEOUT_EN
    // Watchdog expiry after TIMEOUT cycles, and Done on the final cycle
    do_reset();
    hold_done = 1'b1;
    push(OP_SWAP, 2'd0, 8'h00);
    wait_w();
    repeat (TIMEOUT) @(negedge Clock);
    check("timeout_not_early", 32'(err_timeout), 32'd0);
    check("timeout_busy", 32'(busy), 32'd1);
    @(negedge Clock);
    check("timeout_flag", 32'(err_timeout), 32'd1);
    check("timeout_idle", 32'(busy), 32'd0);
    do_reset();
    hold_done = 1'b1;
    push(OP_SWAP, 2'd0, 8'h00);
    wait_w();
    repeat (TIMEOUT) @(negedge Clock);
    hold_done = 1'b0;
    @(negedge Clock);
    check("lastcycle_no_err", 32'(err_timeout), 32'd0);
    check("lastcycle_idle", 32'(busy), 32'd0);
`endif

    // Randomized command stream with random Done latency
    do_reset();
    rand_stall = 1'b1;
    for (int i = 0; i < 80; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge Clock);
      push(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), N'($urandom));
    end
    wait_idle(2000);
    compare_all("random");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
